// File: rtl/decode_regfile_sb.sv
// Register file with write bypass and a per-register pending-write scoreboard.
// Decode uses hazard/iss_ready to stall; writeback retires pending writes.
module decode_regfile_sb #(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 32,
  parameter int NRD     = 2,
  parameter int MAXPEND = 3,
  localparam int AW     = $clog2(NREGS),
  localparam int CW     = $clog2(MAXPEND + 1)
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  WEN,
  input  logic [AW-1:0]         wsel,
  input  logic [DATA_W-1:0]     wdat,
  input  logic [NRD*AW-1:0]     rsel,
  output logic [NRD*DATA_W-1:0] rdat,
  output logic [NRD-1:0]        hazard,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_sel,
  output logic                  iss_ready,
  input  logic                  flush,
  output logic                  idle
);

  logic [DATA_W-1:0] regs     [NREGS];
  logic [CW-1:0]     pend     [NREGS];
  logic [CW-1:0]     pend_nxt [NREGS];

  logic wr_vld;
  logic iss_go;

  assign wr_vld    = WEN && (wsel != '0);
  // Readiness ignores a same-cycle retirement on purpose: it keeps the
  // issue path independent of the writeback timing.
  assign iss_ready = (iss_sel == '0) || (pend[iss_sel] < CW'(MAXPEND));
  assign iss_go    = iss_en && iss_ready && (iss_sel != '0);

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      logic inc;
      logic dec;
      pend_nxt[r] = pend[r];
      inc = iss_go && (iss_sel == AW'(r));
      dec = wr_vld && (wsel == AW'(r)) && (pend[r] != '0);
      if (r == 0 || flush)
        pend_nxt[r] = '0;
      else if (inc && !dec)
        pend_nxt[r] = pend[r] + CW'(1);
      else if (dec && !inc)
        pend_nxt[r] = pend[r] - CW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
        pend[r] <= '0;
      end
    end else begin
      if (wr_vld)
        regs[wsel] <= wdat;
      for (int r = 0; r < NREGS; r++)
        pend[r] <= pend_nxt[r];
    end
  end

  always_comb begin
    rdat   = '0;
    hazard = '0;
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] sel;
      logic          byp;
      sel = rsel[i*AW +: AW];
      byp = wr_vld && (wsel == sel);
      if (sel == '0)
        rdat[i*DATA_W +: DATA_W] = '0;
      else if (byp)
        rdat[i*DATA_W +: DATA_W] = wdat;
      else
        rdat[i*DATA_W +: DATA_W] = regs[sel];
      // The last outstanding write landing this cycle is forwarded, so no stall.
      hazard[i] = (sel != '0) && (pend[sel] != '0) &&
                  !(byp && (pend[sel] == CW'(1)));
    end
  end

  always_comb begin
    idle = 1'b1;
    for (int r = 0; r < NREGS; r++)
      if (pend[r] != '0)
        idle = 1'b0;
  end

endmodule

// File: tb/tb_decode_regfile_sb.sv
// Directed bench for decode_regfile_sb: bypass, x0 behaviour, scoreboard
// saturation, concurrent issue/retire, flush and mid-run reset.
module tb_decode_regfile_sb;

  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int NRD    = 2;
  localparam int AW     = 5;

  logic                  CLK = 1'b0;
  logic                  nRST;
  logic                  WEN;
  logic [AW-1:0]         wsel;
  logic [DATA_W-1:0]     wdat;
  logic [NRD*AW-1:0]     rsel;
  logic [NRD*DATA_W-1:0] rdat;
  logic [NRD-1:0]        hazard;
  logic                  iss_en;
  logic [AW-1:0]         iss_sel;
  logic                  iss_ready;
  logic                  flush;
  logic                  idle;

  int n_chk  = 0;
  int n_fail = 0;

  decode_regfile_sb #(.DATA_W(DATA_W), .NREGS(NREGS), .NRD(NRD), .MAXPEND(3)) dut (
    .CLK(CLK), .nRST(nRST), .WEN(WEN), .wsel(wsel), .wdat(wdat),
    .rsel(rsel), .rdat(rdat), .hazard(hazard), .iss_en(iss_en),
    .iss_sel(iss_sel), .iss_ready(iss_ready), .flush(flush), .idle(idle)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_rd(input int port, input logic [AW-1:0] r);
    rsel[port*AW +: AW] = r;
  endtask

  function automatic logic [DATA_W-1:0] rd(input int port);
    return rdat[port*DATA_W +: DATA_W];
  endfunction

  initial begin
    nRST = 1'b0; WEN = 1'b0; wsel = '0; wdat = '0; rsel = '0;
    iss_en = 1'b0; iss_sel = '0; flush = 1'b0;
    tick(); tick();
    nRST = 1'b1;
    set_rd(0, 5'd5); set_rd(1, 5'd31);
    #1;
    chk("rst_rdat0", rd(0), 0);
    chk("rst_rdat1", rd(1), 0);
    chk("rst_hazard", hazard, 0);
    chk("rst_iss_ready", iss_ready, 1);
    chk("rst_idle", idle, 1);

    // write x5 with same-cycle bypass, then read through the array
    WEN = 1'b1; wsel = 5'd5; wdat = 32'hDEADBEEF; set_rd(0, 5'd5);
    #1 chk("byp_x5", rd(0), 32'hDEADBEEF);
    tick();
    WEN = 1'b0; wdat = '0;
    #1 chk("arr_x5", rd(0), 32'hDEADBEEF);

    // x0 ignores writes
    WEN = 1'b1; wsel = 5'd0; wdat = 32'h1234; set_rd(1, 5'd0);
    #1 chk("x0_same", rd(1), 0);
    tick();
    WEN = 1'b0;
    #1 chk("x0_after", rd(1), 0);

    // top register, bypass on port 1 while port 0 reads the array
    WEN = 1'b1; wsel = 5'd31; wdat = 32'hA5A5_0001; set_rd(1, 5'd31); set_rd(0, 5'd5);
    #1 chk("byp_x31_p1", rd(1), 32'hA5A5_0001);
    chk("arr_x5_p0", rd(0), 32'hDEADBEEF);
    tick();
    WEN = 1'b0;
    #1 chk("arr_x31", rd(1), 32'hA5A5_0001);

    // saturate x7
    iss_en = 1'b1; iss_sel = 5'd7; set_rd(0, 5'd7);
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("x7_ready_%0d", k), iss_ready, 1);
      tick();
    end
    #1 chk("x7_full_ready", iss_ready, 0);
    chk("x7_full_idle", idle, 0);
    chk("x7_full_hazard", hazard[0], 1);
    tick();  // 4th issue must be dropped
    iss_en = 1'b0;
    #1 chk("x7_4th_ready", iss_ready, 0);
    chk("x7_4th_idle", idle, 0);

    WEN = 1'b1; wsel = 5'd7; wdat = 32'h7001;
    #1 chk("x7_w1_hazard", hazard[0], 1);
    chk("x7_w1_ready_conservative", iss_ready, 0);
    tick();
    wdat = 32'h7002;
    #1 chk("x7_w2_hazard", hazard[0], 1);
    tick();
    wdat = 32'h7003;
    #1 chk("x7_w3_hazard", hazard[0], 0);
    chk("x7_w3_byp", rd(0), 32'h7003);
    tick();
    WEN = 1'b0;
    #1 chk("x7_done_idle", idle, 1);
    chk("x7_done_hazard", hazard[0], 0);
    chk("x7_done_ready", iss_ready, 1);

    // concurrent issue and retire on x9
    iss_en = 1'b1; iss_sel = 5'd9; set_rd(0, 5'd9);
    tick();
    WEN = 1'b1; wsel = 5'd9; wdat = 32'h99;
    #1 chk("x9_same_hazard", hazard[0], 0);
    tick();
    iss_en = 1'b0; WEN = 1'b0;
    #1 chk("x9_next_hazard", hazard[0], 1);
    chk("x9_next_idle", idle, 0);
    WEN = 1'b1;
    tick();
    WEN = 1'b0;
    #1 chk("x9_clear_idle", idle, 1);

    // flush overrides issue/retire, write still lands
    iss_en = 1'b1; iss_sel = 5'd3;
    tick();
    iss_sel = 5'd4;
    tick();
    iss_en = 1'b0; set_rd(0, 5'd3); set_rd(1, 5'd4);
    #1 chk("fl_pre_idle", idle, 0);
    chk("fl_pre_hazard", hazard, 2'b11);
    flush = 1'b1; WEN = 1'b1; wsel = 5'd3; wdat = 32'h55; iss_en = 1'b1; iss_sel = 5'd4;
    tick();
    flush = 1'b0; WEN = 1'b0; iss_en = 1'b0;
    #1 chk("fl_idle", idle, 1);
    chk("fl_hazard", hazard, 0);
    chk("fl_x3", rd(0), 32'h55);

    // reset mid-operation
    iss_en = 1'b1; iss_sel = 5'd10; WEN = 1'b1; wsel = 5'd11; wdat = 32'h77;
    tick();
    nRST = 1'b0; wsel = 5'd12; wdat = 32'hFF; iss_sel = 5'd13;
    tick();
    nRST = 1'b1; WEN = 1'b0; iss_en = 1'b0;
    set_rd(0, 5'd11); set_rd(1, 5'd12);
    #1 chk("mr_x11", rd(0), 0);
    chk("mr_x12", rd(1), 0);
    chk("mr_idle", idle, 1);
    chk("mr_ready", iss_ready, 1);
    chk("mr_hazard", hazard, 0);
    set_rd(0, 5'd5); set_rd(1, 5'd3);
    #1 chk("mr_x5", rd(0), 0);
    chk("mr_x3", rd(1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_regfile_sb.md
DECODE_REGFILE_SB -- requirements
Module: decode_regfile_sb

Interface
REQ-001 Parameter DATA_W, default 32, register word width in bits.
REQ-002 Parameter NREGS, default 32, architectural register count (power of 2, 2..64).
REQ-003 Parameter NRD, default 2, number of read ports (1..4).
REQ-004 Parameter MAXPEND, default 3, max outstanding issued writes per register (1..7).
REQ-005 Derived constants SHALL be AW = clog2(NREGS) and CW = clog2(MAXPEND+1); neither SHALL be overridable.
REQ-006 One clock; reset is synchronous and active-low.
REQ-007 CLK  input  1  rising-edge clock for all state.
REQ-008 nRST  input  1  synchronous active-low reset.
REQ-009 WEN  input  1  writeback enable.
REQ-010 wsel  input  AW  writeback destination register.
REQ-011 wdat  input  DATA_W  writeback data.
REQ-012 rsel  input  NRD*AW  read selects; port i occupies bits [i*AW +: AW].
REQ-013 rdat  output  NRD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W].
REQ-014 hazard  output  NRD  per-port flag: operand not yet valid.
REQ-015 iss_en  input  1  decode issues an instruction that will write iss_sel.
REQ-016 iss_sel  input  AW  destination of the issued instruction.
REQ-017 iss_ready  output  1  issue accepted this cycle if iss_en is high.
REQ-018 flush  input  1  discard all outstanding-write tracking (pipeline squash).
REQ-019 idle  output  1  no outstanding writes on any register.

Function
REQ-020 Storage: NREGS x DATA_W array; register 0 SHALL always read 0 and ignore writes.
REQ-021 Write: at a rising CLK with WEN=1 and wsel!=0, reg[wsel] SHALL take wdat; visible through the array from the next cycle.
REQ-022 Read: rdat port i SHALL be combinational (0-cycle latency) from reg[rsel_i].
REQ-023 Bypass: if WEN=1, wsel=rsel_i and wsel!=0, rdat port i SHALL equal wdat in the same cycle.
REQ-024 Scoreboard: each register r!=0 SHALL hold a pending counter pend[r] of CW bits; pend[0] SHALL be constant 0.
REQ-025 iss_ready SHALL be 1 when iss_sel=0 or pend[iss_sel] < MAXPEND, else 0 (combinational).
REQ-026 Increment: iss_en=1, iss_ready=1 and iss_sel!=0 SHALL increment pend[iss_sel] at the next edge.
REQ-027 Issue with iss_ready=0 SHALL be ignored; no state change.
REQ-028 Decrement: WEN=1, wsel!=0 and pend[wsel]>0 SHALL decrement pend[wsel] at the next edge.
REQ-029 WEN to a register with pend=0 SHALL write data and leave the counter at 0 (no underflow).
REQ-030 Simultaneous increment and decrement of the same register SHALL leave its counter unchanged.
REQ-031 iss_ready SHALL NOT consider a same-cycle decrement (conservative; pend=MAXPEND blocks even with a concurrent write).
REQ-032 hazard[i] SHALL be 1 when rsel_i!=0 and pend[rsel_i]!=0, except 0 when WEN=1, wsel=rsel_i and pend[rsel_i]=1 (last write, bypassed).
REQ-033 flush=1 SHALL clear every counter at the next edge, overriding same-cycle increments and decrements; register writes in that cycle SHALL still occur.
REQ-034 idle SHALL be 1 exactly when every pend[r]=0 (registered state, not next-state).
REQ-035 Counters SHALL never exceed MAXPEND and never wrap.

Reset
REQ-036 nRST=0 at a rising CLK SHALL clear all registers to 0 and all counters to 0, overriding WEN, iss_en and flush.
REQ-037 After reset: rdat all 0, hazard all 0, iss_ready=1, idle=1.
REQ-038 Reset asserted mid-operation (counters non-zero) SHALL return to the REQ-037 state after one edge.

Verification
REQ-039 Write x5=0xDEADBEEF with rsel_0=5 same cycle -> rdat_0=0xDEADBEEF (bypass); next cycle, WEN=0 -> rdat_0 still 0xDEADBEEF.
REQ-040 WEN=1, wsel=0, wdat=0x1234; read rsel_1=0 -> rdat_1=0 in that cycle and after.
REQ-041 Issue x7 three times (MAXPEND=3) -> iss_ready=0 with iss_sel=7, idle=0, hazard=1 for rsel=7; 4th issue ignored; three WEN writes to x7 -> pend 0, idle=1; hazard=0 during the third write.
REQ-042 pend[9]=1; same cycle iss_en(9) and WEN(9) -> pend[9] stays 1, hazard for rsel=9 stays 1 next cycle.
REQ-043 Outstanding writes on x3,x4; flush=1 with WEN x3=0x55 -> next cycle idle=1, hazard=0, reg[3]=0x55.
REQ-044 Non-zero state, nRST=0 one edge with WEN=1 and iss_en=1 -> all reads 0, idle=1, iss_ready=1.
